// File: rtl/dsp_mac_sequencer_if.sv
// Bundle of the operand stream, result stream and DSP-slice control/data
// signals around dsp_mac_sequencer.
//   slave  : sequencer view (consumes s_*, produces m_*, drives DSP A/B/OPMODE/CEP,
//            reads DSP P/CARRYOUT)
//   master : environment view (upstream source, downstream sink and DSP slice)
interface dsp_mac_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        s_last;

  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_cep;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  logic        m_ovf;

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready, dsp_p, dsp_carryout,
    output s_ready, m_valid, m_data, m_ovf, dsp_a, dsp_b, dsp_opmode, dsp_cep
  );

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready, dsp_p, dsp_carryout,
    input  s_ready, m_valid, m_data, m_ovf, dsp_a, dsp_b, dsp_opmode, dsp_cep
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer in front of a DSP48-style MAC slice.
// Accepts unsigned 18x18 operand pairs, registers them onto the DSP A/B ports,
// and steers OPMODE/CEP so the slice accumulates one vector into P. The last
// product's P is captured as the result together with a sticky carry flag.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - dsp_mac_sequencer_if.slave: s_* operand stream, m_* result stream,
//          dsp_a/dsp_b/dsp_opmode/dsp_cep to the slice, dsp_p/dsp_carryout back
module dsp_mac_sequencer #(
  parameter int PROD_LAT = 2,  // dsp_a/b presentation -> product at post-adder
  parameter int CTRL_LAT = 1   // OPMODE register delay inside the slice
) (
  input  logic                clk,
  input  logic                rst,
  dsp_mac_sequencer_if.slave  bus
);
  // Tag pipeline: stage 0 is the beat being accepted this cycle, stage k is
  // that beat k cycles later. CEP_STG is the cycle its product sits at the
  // post-adder, STG the cycle its P/CARRYOUT are visible.
  localparam int CEP_STG = PROD_LAT + 1;
  localparam int STG     = PROD_LAT + 2;
  localparam int OPM_STG = PROD_LAT - CTRL_LAT;

  localparam logic [7:0] OPM_IDLE  = 8'h00;
  localparam logic [7:0] OPM_FIRST = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC   = 8'h09;  // P = P + M

  logic        accept;
  logic        s_ready_int;
  logic        post_vld;
  logic        capture;
  logic        ovf_new;

  logic [STG:0] vld_pipe;
  logic [STG:0] first_pipe;
  logic [STG:0] last_pipe;

  logic [STG:1] vld_pipe_q,   vld_pipe_d;
  logic [STG:1] first_pipe_q, first_pipe_d;
  logic [STG:1] last_pipe_q,  last_pipe_d;

  logic        first_pend_q, first_pend_d;
  logic        busy_q,       busy_d;
  logic [17:0] dsp_a_q,      dsp_a_d;
  logic [17:0] dsp_b_q,      dsp_b_d;
  logic [7:0]  opmode_q,     opmode_d;
  logic        ovf_acc_q,    ovf_acc_d;
  logic        m_valid_q,    m_valid_d;
  logic [47:0] m_data_q,     m_data_d;
  logic        m_ovf_q,      m_ovf_d;

  // busy spans from the last beat's acceptance to its result handshake, so a
  // second result can never race the first into m_data.
  assign s_ready_int = !rst && !busy_q;
  assign accept      = bus.s_valid && s_ready_int;

  assign vld_pipe   = {vld_pipe_q,   accept};
  assign first_pipe = {first_pipe_q, first_pend_q};
  assign last_pipe  = {last_pipe_q,  bus.s_last};

  always_comb begin
    vld_pipe_d   = vld_pipe[STG-1:0];
    first_pipe_d = first_pipe[STG-1:0];
    last_pipe_d  = last_pipe[STG-1:0];

    dsp_a_d = accept ? bus.s_a : dsp_a_q;
    dsp_b_d = accept ? bus.s_b : dsp_b_q;

    // Issued early by CTRL_LAT so the slice's OPMODE register lines up with
    // the product reaching the post-adder.
    opmode_d = OPM_IDLE;
    if (vld_pipe[OPM_STG])
      opmode_d = first_pipe[OPM_STG] ? OPM_FIRST : OPM_ACC;

    // Carry of the add that just landed in P; the first product restarts it.
    post_vld  = vld_pipe[STG];
    ovf_new   = (!first_pipe[STG] && ovf_acc_q) || bus.dsp_carryout;
    ovf_acc_d = post_vld ? ovf_new : ovf_acc_q;

    capture   = post_vld && last_pipe[STG];
    m_valid_d = capture || (m_valid_q && !bus.m_ready);
    m_data_d  = capture ? bus.dsp_p : m_data_q;
    m_ovf_d   = capture ? ovf_new   : m_ovf_q;

    first_pend_d = accept ? bus.s_last : first_pend_q;

    busy_d = busy_q;
    if (accept && bus.s_last)
      busy_d = 1'b1;
    else if (m_valid_q && bus.m_ready)
      busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      first_pend_q <= 1'b1;
      busy_q       <= 1'b0;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      opmode_q     <= OPM_IDLE;
      ovf_acc_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
      first_pend_q <= first_pend_d;
      busy_q       <= busy_d;
      dsp_a_q      <= dsp_a_d;
      dsp_b_q      <= dsp_b_d;
      opmode_q     <= opmode_d;
      ovf_acc_q    <= ovf_acc_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_ovf_q      <= m_ovf_d;
    end
  end

  // Outputs forced idle for the whole reset window, including the first
  // reset cycle before the registers have been cleared.
  assign bus.s_ready    = s_ready_int;
  assign bus.dsp_a      = rst ? '0 : dsp_a_q;
  assign bus.dsp_b      = rst ? '0 : dsp_b_q;
  assign bus.dsp_opmode = rst ? OPM_IDLE : opmode_q;
  assign bus.dsp_cep    = !rst && vld_pipe[CEP_STG];
  assign bus.m_valid    = !rst && m_valid_q;
  assign bus.m_data     = rst ? '0 : m_data_q;
  assign bus.m_ovf      = !rst && m_ovf_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if bus();

  dsp_mac_sequencer #(.PROD_LAT(2), .CTRL_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         acc_log[$];
  int         cep_log[$];
  int         opm_cyc[$];
  logic [7:0] opm_log[$];

  typedef struct packed { logic [47:0] data; logic ovf; } res_t;
  res_t exp_q[$];

  // DSP slice stand-in: A1/B1 reg, M reg, OPMODE reg, P with carry out.
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m_r = '0;
  logic [7:0]  opm_r = '0;
  logic [47:0] p_r = '0;
  logic        co_r = 1'b0;
  logic [47:0] xs, zs;
  logic [48:0] sum_w;

  always_comb begin
    xs    = (opm_r == 8'h01 || opm_r == 8'h09) ? {12'b0, m_r} : 48'd0;
    zs    = (opm_r == 8'h09) ? p_r : 48'd0;
    sum_w = {1'b0, zs} + {1'b0, xs};
  end

  always @(posedge clk) begin
    a1    <= bus.dsp_a;
    b1    <= bus.dsp_b;
    m_r   <= a1 * b1;
    opm_r <= bus.dsp_opmode;
    if (bus.dsp_cep) {co_r, p_r} <= sum_w;
  end

  assign bus.dsp_p        = p_r;
  assign bus.dsp_carryout = co_r;

  // Edge e records cyc==e; the following negedge sees cyc==e+1 (cycle e+1).
  always @(posedge clk) begin
    if (bus.s_valid && bus.s_ready) acc_log.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bus.dsp_cep) cep_log.push_back(cyc);
    if (bus.dsp_opmode != 8'h00) begin
      opm_log.push_back(bus.dsp_opmode);
      opm_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model_result(input logic [63:0] true_sum);
    res_t r;
    r.data = true_sum[47:0];
    r.ovf  = (true_sum[63:48] != 16'd0);
    return r;
  endfunction

  task automatic clear_logs();
    acc_log.delete(); cep_log.delete(); opm_log.delete(); opm_cyc.delete();
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    int n = 0;
    bus.s_a = a; bus.s_b = b; bus.s_last = last; bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout s_ready=%b required 1", bus.s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    int n = 0;
    while (bus.m_valid !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    ok = (n < 300);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_result_timeout m_valid=%b required 1", bus.m_valid);
    end
  endtask

  task automatic take_result();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.dsp_cep !== 1'b0 || bus.m_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl s_ready=%b m_valid=%b cep=%b ovf=%b required all 0",
               bus.s_ready, bus.m_valid, bus.dsp_cep, bus.m_ovf);
    end
    checks++;
    if (bus.m_data !== 48'd0 || bus.dsp_a !== 18'd0 || bus.dsp_b !== 18'd0 || bus.dsp_opmode !== 8'h00) begin
      failures++;
      $display("FAIL reset_data m_data=%0d a=%0d b=%0d opmode=%h required 0",
               bus.m_data, bus.dsp_a, bus.dsp_b, bus.dsp_opmode);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready s_ready=%b required 1", bus.s_ready);
    end
  endtask

  task automatic test_single();
    clear_logs();
    bus.m_ready = 1'b0;
    bus.s_a = 18'd3; bus.s_b = 18'd5; bus.s_last = 1'b1; bus.s_valid = 1'b1;
    @(posedge clk);                      // edge t
    @(negedge clk); bus.s_valid = 1'b0;  // cycle t+1
    checks++;
    if (bus.dsp_a !== 18'd3 || bus.dsp_b !== 18'd5) begin
      failures++;
      $display("FAIL single_operands a=%0d b=%0d required 3 5", bus.dsp_a, bus.dsp_b);
    end
    checks++;
    if (bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready_drop s_ready=%b required 0", bus.s_ready);
    end
    @(negedge clk);                      // cycle t+2
    checks++;
    if (bus.dsp_opmode !== 8'h01 || bus.dsp_cep !== 1'b0 || bus.dsp_a !== 18'd3) begin
      failures++;
      $display("FAIL single_opmode opmode=%h cep=%b a=%0d required 01 0 3", bus.dsp_opmode, bus.dsp_cep, bus.dsp_a);
    end
    @(negedge clk);                      // cycle t+3
    checks++;
    if (bus.dsp_cep !== 1'b1) begin
      failures++;
      $display("FAIL single_cep cep=%b required 1", bus.dsp_cep);
    end
    @(negedge clk);                      // cycle t+4
    checks++;
    if (bus.m_valid !== 1'b0 || bus.dsp_cep !== 1'b0) begin
      failures++;
      $display("FAIL single_early m_valid=%b cep=%b required 0 0", bus.m_valid, bus.dsp_cep);
    end
    @(negedge clk);                      // cycle t+5
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 48'd15 || bus.m_ovf !== 1'b0) begin
      failures++;
      $display("FAIL single_result m_valid=%b data=%0d ovf=%b required 1 15 0", bus.m_valid, bus.m_data, bus.m_ovf);
    end
    take_result();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_release m_valid=%b s_ready=%b required 0 1", bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    send_beat(18'd1, 18'd2, 1'b0);
    send_beat(18'd3, 18'd4, 1'b0);
    send_beat(18'd5, 18'd6, 1'b0);
    send_beat(18'd7, 18'd8, 1'b1);
    checks++;
    if (bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_after_last s_ready=%b required 0", bus.s_ready);
    end
    checks++;
    if (acc_log.size() != 4 || acc_log[3] != acc_log[0] + 3) begin
      failures++;
      $display("FAIL b2b_accept_rate accepts=%0d required 4 consecutive", acc_log.size());
    end
    wait_result(ok);
    checks++;
    if (bus.m_data !== 48'd100 || bus.m_ovf !== 1'b0 || bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result data=%0d ovf=%b s_ready=%b required 100 0 0", bus.m_data, bus.m_ovf, bus.s_ready);
    end
    checks++;
    if (opm_log.size() != 4 || opm_log[0] != 8'h01 || opm_log[1] != 8'h09 ||
        opm_log[2] != 8'h09 || opm_log[3] != 8'h09 || opm_cyc[3] != opm_cyc[0] + 3 ||
        opm_cyc[0] != acc_log[0] + 2) begin
      failures++;
      $display("FAIL b2b_opmodes count=%0d required 01,09,09,09 consecutive at accept+2", opm_log.size());
    end
    take_result();
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_release s_ready=%b required 1", bus.s_ready);
    end
  endtask

  task automatic test_gapped();
    bit ok;
    clear_logs();
    bus.s_a = 18'd2; bus.s_b = 18'd3; bus.s_last = 1'b0; bus.s_valid = 1'b1;
    @(negedge clk); bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.s_a = 18'd4; bus.s_b = 18'd5; bus.s_last = 1'b1; bus.s_valid = 1'b1;
    @(negedge clk); bus.s_valid = 1'b0;
    wait_result(ok);
    checks++;
    if (bus.m_data !== 48'd26 || bus.m_ovf !== 1'b0) begin
      failures++;
      $display("FAIL gapped_result data=%0d ovf=%b required 26 0", bus.m_data, bus.m_ovf);
    end
    checks++;
    if (acc_log.size() != 2 || cep_log.size() != 2 ||
        cep_log[0] != acc_log[0] + 3 || cep_log[1] != acc_log[1] + 3) begin
      failures++;
      $display("FAIL gapped_cep cep_count=%0d accepts=%0d required 2 at accept+3", cep_log.size(), acc_log.size());
    end
    take_result();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [63:0] sum = 64'd0;
    int len = $urandom_range(1, 5);
    res_t exp_r;
    for (int i = 0; i < len; i++) begin
      logic [17:0] a = 18'($urandom);
      logic [17:0] b = 18'($urandom);
      sum += 64'(a) * 64'(b);
      send_beat(a, b, (i == len - 1));
    end
    exp_r = model_result(sum);
    wait_result(ok);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_r.data || bus.m_ovf !== exp_r.ovf || bus.s_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d valid=%b data=%0d ovf=%b ready=%b required 1 %0d %b 0",
                 c, bus.m_valid, bus.m_data, bus.m_ovf, bus.s_ready, exp_r.data, exp_r.ovf);
      end
      @(negedge clk);
    end
    take_result();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release m_valid=%b s_ready=%b required 0 1", bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [63:0] big, target, n, r, hi, lo, sum;
    res_t exp_r;
    big    = 64'(18'h3FFFF) * 64'(18'h3FFFF);
    target = (64'd1 << 48) - 64'd1;
    n      = target / big;
    r      = target - n * big;
    hi     = r >> 17;
    lo     = r & 64'h1FFFF;
    for (longint i = 0; i < longint'(n); i++) send_beat(18'h3FFFF, 18'h3FFFF, 1'b0);
    send_beat(18'(hi / 2), 18'd131072, 1'b0);
    send_beat(18'(hi - hi / 2), 18'd131072, 1'b0);
    send_beat(18'(lo), 18'd1, 1'b0);
    send_beat(18'd1, 18'd1, 1'b1);
    wait_result(ok);
    checks++;
    if (bus.m_data !== 48'd0 || bus.m_ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_wrap data=%0d ovf=%b required 0 1", bus.m_data, bus.m_ovf);
    end
    take_result();
    sum = 64'd0;
    for (int i = 0; i < 2; i++) begin
      logic [17:0] a = 18'($urandom);
      logic [17:0] b = 18'($urandom);
      sum += 64'(a) * 64'(b);
      send_beat(a, b, (i == 1));
    end
    exp_r = model_result(sum);
    wait_result(ok);
    checks++;
    if (bus.m_data !== exp_r.data || bus.m_ovf !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear data=%0d ovf=%b required %0d 0", bus.m_data, bus.m_ovf, exp_r.data);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_beat(18'd9, 18'd9, 1'b0);
    send_beat(18'd7, 18'd7, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dsp_cep !== 1'b0 || bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_during cep=%b s_ready=%b required 0 0", bus.dsp_cep, bus.s_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.m_valid !== 1'b0 || bus.dsp_cep !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet cyc=%0d m_valid=%b cep=%b required 0 0", c, bus.m_valid, bus.dsp_cep);
      end
      @(negedge clk);
    end
    send_beat(18'd2, 18'd2, 1'b1);
    wait_result(ok);
    checks++;
    if (bus.m_data !== 48'd4 || bus.m_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_next data=%0d ovf=%b required 4 0", bus.m_data, bus.m_ovf);
    end
    take_result();
  endtask

  task automatic test_random();
    localparam int NVEC = 10;
    exp_q.delete();
    fork
      begin : driver
        for (int v = 0; v < NVEC; v++) begin
          logic [63:0] sum = 64'd0;
          int len = $urandom_range(1, 6);
          for (int i = 0; i < len; i++) begin
            logic [17:0] a = 18'($urandom);
            logic [17:0] b = 18'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sum += 64'(a) * 64'(b);
            if (i == len - 1) exp_q.push_back(model_result(sum));
            send_beat(a, b, (i == len - 1));
          end
        end
      end
      begin : collector
        for (int v = 0; v < NVEC; v++) begin
          bit ok;
          res_t exp_r;
          wait_result(ok);
          if (ok) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL random_unexpected vec=%0d data=%0d required no result", v, bus.m_data);
            end else begin
              exp_r = exp_q.pop_front();
              if (bus.m_data !== exp_r.data || bus.m_ovf !== exp_r.ovf) begin
                failures++;
                $display("FAIL random_result vec=%0d data=%0d ovf=%b required %0d %b",
                         v, bus.m_data, bus.m_ovf, exp_r.data, exp_r.ovf);
              end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take_result();
          end
        end
      end
    join
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
